// File: rtl/alu_mul_seq_if.sv
// Request/result handshake plus the ALU operand/control lines owned by the multiply sequencer.
// master = control unit + ALU side, slave = sequencer.
interface alu_mul_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_addr_src_b_sel;
    logic [1:0]  alu_primary_out_sel;
    logic        alu_shifter_enbl;
    logic [1:0]  alu_shift_type;
    logic [4:0]  alu_shift_amnt;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_c_out;

    modport master (
        output start, op_a, op_b, alu_out, alu_zero, alu_c_out,
        input  busy, done, result, ovf, alu_a, alu_b, alu_addr_src_b_sel,
               alu_primary_out_sel, alu_shifter_enbl, alu_shift_type, alu_shift_amnt
    );

    modport slave (
        input  start, op_a, op_b, alu_out, alu_zero, alu_c_out,
        output busy, done, result, ovf, alu_a, alu_b, alu_addr_src_b_sel,
               alu_primary_out_sel, alu_shifter_enbl, alu_shift_type, alu_shift_amnt
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add 32x32 unsigned multiply (low word + overflow flag) that time-shares the main ALU.
// Latency 2 + sum(3 + multiplier bit) cycles; start is accepted only in IDLE, no other backpressure.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  iter;
    logic        ovf_r;
    logic [31:0] result_q;
    logic        ovf_q;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic        alu_sh_en;
    logic [1:0]  alu_sh_type;
    logic [4:0]  alu_sh_amnt;

    always_comb begin
        state_nxt   = state;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = 2'd0;
        alu_sh_en   = 1'b0;
        alu_sh_type = 2'd0;
        alu_sh_amnt = 5'd0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // ALU zero flag tests the remaining multiplier without a local comparator
                alu_a = mplier;
                if ((EARLY_EXIT && bus.alu_zero) || (iter == 6'd32)) state_nxt = S_DONE;
                else if (mplier[0])                                   state_nxt = S_ADD;
                else                                                  state_nxt = S_SHL;
            end
            S_ADD: begin
                alu_a     = acc;
                alu_b     = mcand;
                alu_sel   = 2'd1;
                state_nxt = S_SHL;
            end
            S_SHL: begin
                alu_a       = mcand;
                alu_sh_en   = 1'b1;
                alu_sh_type = 2'd0;
                alu_sh_amnt = 5'd1;
                state_nxt   = S_SHR;
            end
            S_SHR: begin
                alu_a       = mplier;
                alu_sh_en   = 1'b1;
                alu_sh_type = 2'd1;
                alu_sh_amnt = 5'd1;
                state_nxt   = S_CHECK;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            iter     <= '0;
            ovf_r    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        mcand    <= bus.op_a;
                        mplier   <= bus.op_b;
                        iter     <= '0;
                        ovf_r    <= 1'b0;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    // load on entry to DONE so result/ovf are already valid during the done pulse
                    if (state_nxt == S_DONE) begin
                        result_q <= acc;
                        ovf_q    <= ovf_r;
                    end
                end
                S_ADD: begin
                    acc <= bus.alu_out;
                    if (bus.alu_c_out) ovf_r <= 1'b1;
                end
                S_SHL: begin
                    mcand <= bus.alu_out;
                    // a bit shifted out of mcand still has higher multiplier bits to multiply it
                    if (mcand[31] && (mplier[31:1] != '0)) ovf_r <= 1'b1;
                end
                S_SHR: begin
                    mplier <= bus.alu_out;
                    iter   <= iter + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy                = (state != S_IDLE);
    assign bus.done                = (state == S_DONE);
    assign bus.result              = result_q;
    assign bus.ovf                 = ovf_q;
    assign bus.alu_a               = alu_a;
    assign bus.alu_b               = alu_b;
    assign bus.alu_addr_src_b_sel  = 1'b0;
    assign bus.alu_primary_out_sel = alu_sel;
    assign bus.alu_shifter_enbl    = alu_sh_en;
    assign bus.alu_shift_type      = alu_sh_type;
    assign bus.alu_shift_amnt      = alu_sh_amnt;

endmodule
